// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between uart_cmd_ctrl and its RX, register-file, ALU and TX-FIFO neighbours.
// master = the controller, slave = the surrounding blocks.
interface uart_cmd_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
);
  logic [DATA_WIDTH-1:0]   RX_P_DATA;
  logic                    RX_D_VLD;
  logic [ADDR_WIDTH-1:0]   RF_Address;
  logic                    RF_WrEn;
  logic                    RF_RdEn;
  logic [DATA_WIDTH-1:0]   RF_WrData;
  logic [DATA_WIDTH-1:0]   RF_RdData;
  logic                    RF_RdData_Valid;
  logic                    ALU_EN;
  logic [FUN_WIDTH-1:0]    ALU_FUN;
  logic                    CLK_GATE_EN;
  logic [2*DATA_WIDTH-1:0] ALU_OUT;
  logic                    ALU_OUT_Valid;
  logic [DATA_WIDTH-1:0]   TX_P_DATA;
  logic                    TX_D_VLD;
  logic                    FIFO_FULL;

  modport master (
    input  RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_Valid, FIFO_FULL,
    output RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD
  );

  modport slave (
    output RX_P_DATA, RX_D_VLD, RF_RdData, RF_RdData_Valid, ALU_OUT, ALU_OUT_Valid, FIFO_FULL,
    input  RF_Address, RF_WrEn, RF_RdEn, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN,
           TX_P_DATA, TX_D_VLD
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Command-frame parser: turns RX bytes into register-file writes/reads and ALU runs,
// and returns read data / ALU results as bytes to the TX FIFO.
module uart_cmd_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned FUN_WIDTH  = 4
) (
  input logic            CLK,
  input logic            RST,
  uart_cmd_ctrl_if.master bus
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B,
    ALU_FUN_S, ALU_WAIT, TX_LO, TX_HI, TX_RD
  } state_t;

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [DATA_WIDTH-1:0] wr_data, wr_data_nx;
  logic                  wr_en, wr_en_nx;
  logic                  rd_en, rd_en_nx;
  logic                  alu_en, alu_en_nx;
  logic [FUN_WIDTH-1:0]  alu_fun, alu_fun_nx;
  logic                  gate_en, gate_en_nx;
  logic [DATA_WIDTH-1:0] tx_data, tx_data_nx;
  logic                  tx_vld, tx_vld_nx;
  logic [DATA_WIDTH-1:0] alu_hi, alu_hi_nx;

  // Next-state and next-output decode; strobes default low, everything else holds.
  always_comb begin
    state_nx   = state;
    addr_nx    = addr;
    wr_data_nx = wr_data;
    wr_en_nx   = 1'b0;
    rd_en_nx   = rd_en;
    alu_en_nx  = 1'b0;
    alu_fun_nx = alu_fun;
    gate_en_nx = gate_en;
    tx_data_nx = tx_data;
    tx_vld_nx  = 1'b0;
    alu_hi_nx  = alu_hi;

    case (state)
      IDLE: begin
        if (bus.RX_D_VLD) begin
          case (bus.RX_P_DATA)
            CMD_WR:     state_nx = WR_ADDR;
            CMD_RD:     state_nx = RD_ADDR;
            CMD_ALU_OP: state_nx = OP_A;
            CMD_ALU:    state_nx = ALU_FUN_S;
            default:    state_nx = IDLE;
          endcase
        end
      end
      WR_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_nx  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          state_nx = WR_DATA;
        end
      end
      WR_DATA: begin
        if (bus.RX_D_VLD) begin
          wr_data_nx = bus.RX_P_DATA;
          wr_en_nx   = 1'b1;
          state_nx   = IDLE;
        end
      end
      RD_ADDR: begin
        if (bus.RX_D_VLD) begin
          addr_nx  = bus.RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_nx = 1'b1;
          state_nx = RD_WAIT;
        end
      end
      // Read data goes straight into the TX holding register so it stays stable while blocked.
      RD_WAIT: begin
        if (bus.RF_RdData_Valid) begin
          rd_en_nx   = 1'b0;
          tx_data_nx = bus.RF_RdData;
          state_nx   = TX_RD;
        end
      end
      OP_A: begin
        if (bus.RX_D_VLD) begin
          addr_nx    = '0;
          wr_data_nx = bus.RX_P_DATA;
          wr_en_nx   = 1'b1;
          state_nx   = OP_B;
        end
      end
      OP_B: begin
        if (bus.RX_D_VLD) begin
          addr_nx    = ADDR_WIDTH'(1);
          wr_data_nx = bus.RX_P_DATA;
          wr_en_nx   = 1'b1;
          state_nx   = ALU_FUN_S;
        end
      end
      ALU_FUN_S: begin
        if (bus.RX_D_VLD) begin
          alu_fun_nx = bus.RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_nx  = 1'b1;
          gate_en_nx = 1'b1;
          state_nx   = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (bus.ALU_OUT_Valid) begin
          gate_en_nx = 1'b0;
          tx_data_nx = bus.ALU_OUT[DATA_WIDTH-1:0];
          alu_hi_nx  = bus.ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
          state_nx   = TX_LO;
        end
      end
      TX_LO: begin
        if (!bus.FIFO_FULL && !tx_vld) begin
          tx_vld_nx = 1'b1;
          state_nx  = TX_HI;
        end
      end
      // First cycle here is the low-byte strobe: swap in the high byte, then send it.
      TX_HI: begin
        if (tx_vld) begin
          tx_data_nx = alu_hi;
        end else if (!bus.FIFO_FULL) begin
          tx_vld_nx  = 1'b1;
          alu_fun_nx = '0;
          state_nx   = IDLE;
        end
      end
      TX_RD: begin
        if (!bus.FIFO_FULL && !tx_vld) begin
          tx_vld_nx = 1'b1;
          state_nx  = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      addr    <= '0;
      wr_data <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      alu_en  <= 1'b0;
      alu_fun <= '0;
      gate_en <= 1'b0;
      tx_data <= '0;
      tx_vld  <= 1'b0;
      alu_hi  <= '0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      wr_data <= wr_data_nx;
      wr_en   <= wr_en_nx;
      rd_en   <= rd_en_nx;
      alu_en  <= alu_en_nx;
      alu_fun <= alu_fun_nx;
      gate_en <= gate_en_nx;
      tx_data <= tx_data_nx;
      tx_vld  <= tx_vld_nx;
      alu_hi  <= alu_hi_nx;
    end
  end

  assign bus.RF_Address  = addr;
  assign bus.RF_WrData   = wr_data;
  assign bus.RF_WrEn     = wr_en;
  assign bus.RF_RdEn     = rd_en;
  assign bus.ALU_EN      = alu_en;
  assign bus.ALU_FUN     = alu_fun;
  assign bus.CLK_GATE_EN = gate_en;
  assign bus.TX_P_DATA   = tx_data;
  assign bus.TX_D_VLD    = tx_vld;

endmodule
